// File: rtl/wb_port_arbiter_if.sv
// Bus bundle between the writeback arbiter and its neighbours: the pipeline
// W stage, the long-latency unit, the register-file write port and the
// decode/hazard logic that consumes the stall outputs.
// slave  : view taken by wb_port_arbiter
// master : view taken by the surrounding pipeline (or a bench)
interface wb_port_arbiter_if;
  logic        pipe_we;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        ll_issue;
  logic [4:0]  ll_issue_rd;
  logic        ll_valid;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        ll_ready;
  logic        RegWrite;
  logic [4:0]  rd;
  logic [31:0] WD3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        stall_rs1;
  logic        stall_rs2;
  logic        issue_stall;
  logic        pending_any;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data,
    input  ll_issue, ll_issue_rd,
    input  ll_valid, ll_rd, ll_data,
    output ll_ready,
    output RegWrite, rd, WD3,
    input  rs1, rs2,
    output stall_rs1, stall_rs2, issue_stall, pending_any
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data,
    output ll_issue, ll_issue_rd,
    output ll_valid, ll_rd, ll_data,
    input  ll_ready,
    input  RegWrite, rd, WD3,
    output rs1, rs2,
    input  stall_rs1, stall_rs2, issue_stall, pending_any
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the register file's single write port
// between the in-order pipeline writeback and a long-latency (mul/div) unit.
// LL results wait in a small circular FIFO until the port is free; a 32-bit
// pending scoreboard tracks registers still owed by the LL unit.
// Optional build macro WB_BYPASS_EN: with an empty FIFO and an idle port,
// an arriving LL result is written in the same cycle instead of buffered.
module wb_port_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_port_arbiter_if.slave bus
);

  localparam int DATA_W = 32;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // Buffered LL results; storage is data only and is never reset.
  logic [4:0]        fifo_rd   [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];

  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [31:0]       busy;

  logic              full;
  logic              empty;
  logic              pipe_eff;
  logic              drain;
  logic              bypass;
  logic              accept;
  logic              push;
  logic              issue_ok;
  logic [4:0]        head_rd;
  logic [DATA_W-1:0] head_data;

  logic              reg_write;
  logic [4:0]        wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic [31:0]       set_vec;
  logic [31:0]       clr_vec;
  logic [31:0]       busy_next;
  logic [CNT_W-1:0]  count_next;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign head_rd   = fifo_rd[rd_ptr];
  assign head_data = fifo_data[rd_ptr];

  // A pipeline write to x0 is a no-op and leaves the port free.
  assign pipe_eff  = bus.pipe_we && (bus.pipe_rd != 5'd0);
  assign drain     = rst_n && !pipe_eff && !empty;

`ifdef WB_BYPASS_EN
  // Same-cycle forwarding only when nothing older is queued, so order holds.
  assign bypass    = rst_n && empty && !pipe_eff && bus.ll_valid && (bus.ll_rd != 5'd0);
`else
  assign bypass    = 1'b0;
`endif

  // ll_ready looks at the registered occupancy only, so a pop in a full
  // cycle does not open a slot until the next cycle.
  assign bus.ll_ready = rst_n && !full;
  assign accept       = bus.ll_valid && bus.ll_ready;
  // Results for x0 are acknowledged and dropped.
  assign push         = accept && (bus.ll_rd != 5'd0) && !bypass;

  assign bus.issue_stall = rst_n && bus.ll_issue && busy[bus.ll_issue_rd];
  assign issue_ok        = rst_n && bus.ll_issue && !busy[bus.ll_issue_rd]
                           && (bus.ll_issue_rd != 5'd0);

  assign bus.stall_rs1   = rst_n && busy[bus.rs1] && (bus.rs1 != 5'd0);
  assign bus.stall_rs2   = rst_n && busy[bus.rs2] && (bus.rs2 != 5'd0);
  assign bus.pending_any = rst_n && (|busy);

  // Write-port selection: pipeline first, then FIFO head, then bypass.
  always_comb begin
    reg_write = 1'b0;
    wr_rd     = 5'd0;
    wr_data   = '0;
    if (rst_n) begin
      if (pipe_eff) begin
        reg_write = 1'b1;
        wr_rd     = bus.pipe_rd;
        wr_data   = bus.pipe_data;
      end else if (drain) begin
        reg_write = 1'b1;
        wr_rd     = head_rd;
        wr_data   = head_data;
      end else if (bypass) begin
        reg_write = 1'b1;
        wr_rd     = bus.ll_rd;
        wr_data   = bus.ll_data;
      end
    end
  end

  assign bus.RegWrite = reg_write;
  assign bus.rd       = wr_rd;
  assign bus.WD3      = wr_data;

  // Scoreboard next state: an issue setting a bit beats a retire clearing it.
  always_comb begin
    set_vec   = 32'd0;
    clr_vec   = 32'd0;
    if (issue_ok) set_vec = 32'd1 << bus.ll_issue_rd;
    if (drain)    clr_vec = 32'd1 << head_rd;
    if (bypass)   clr_vec = 32'd1 << bus.ll_rd;
    busy_next    = (busy & ~clr_vec) | set_vec;
    busy_next[0] = 1'b0;
  end

  // Occupancy next state from push/pop.
  always_comb begin
    count_next = count;
    case ({push, drain})
      2'b10:   count_next = count + CNT_W'(1);
      2'b01:   count_next = count - CNT_W'(1);
      default: count_next = count;
    endcase
  end

  // Control state: pointers, occupancy and scoreboard; reset drops everything.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= 32'd0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
      if (drain) rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
      busy  <= busy_next;
    end
  end

  // FIFO storage write; contents are qualified by the control state only.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.ll_rd;
      fifo_data[wr_ptr] <= bus.ll_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: expected register-file writes from the LL unit
// are queued when the result is driven and popped when the port writes.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus.pipe_we     = 1'b0;
    bus.pipe_rd     = 5'd0;
    bus.pipe_data   = 32'd0;
    bus.ll_issue    = 1'b0;
    bus.ll_issue_rd = 5'd0;
    bus.ll_valid    = 1'b0;
    bus.ll_rd       = 5'd0;
    bus.ll_data     = 32'd0;
  endtask

  task automatic drive_pipe(input logic [4:0] r, input logic [31:0] d);
    bus.pipe_we   = 1'b1;
    bus.pipe_rd   = r;
    bus.pipe_data = d;
  endtask

  task automatic drive_ll(input logic [4:0] r, input logic [31:0] d, input bit will_accept);
    bus.ll_valid = 1'b1;
    bus.ll_rd    = r;
    bus.ll_data  = d;
    if (will_accept && r != 5'd0) exp_q.push_back('{rd: r, data: d});
  endtask

  // Write monitor: pipeline writes must pass straight through; any other
  // write must be the oldest outstanding LL result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.pipe_we && bus.pipe_rd != 5'd0) begin
        check_eq("pipe_regwrite", 64'(bus.RegWrite), 64'd1);
        check_eq("pipe_rd", 64'(bus.rd), 64'(bus.pipe_rd));
        check_eq("pipe_wd3", 64'(bus.WD3), 64'(bus.pipe_data));
      end else if (bus.RegWrite) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write", 64'(bus.RegWrite), 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("ll_rd", 64'(bus.rd), 64'(mon_e.rd));
          check_eq("ll_wd3", 64'(bus.WD3), 64'(mon_e.data));
        end
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    bus.rs1 = 5'd0;
    bus.rs2 = 5'd0;
    bus.ll_valid = 1'b1;
    bus.ll_rd    = 5'd2;
    bus.ll_data  = 32'h1111;

    // Reset held two cycles with an LL result offered
    for (int i = 0; i < 2; i++) begin
      sample();
      check_eq("rst_regwrite", 64'(bus.RegWrite), 64'd0);
      check_eq("rst_ll_ready", 64'(bus.ll_ready), 64'd0);
      check_eq("rst_pending", 64'(bus.pending_any), 64'd0);
      tick();
    end
    rst_n = 1'b1;
    idle_inputs();
    sample();
    check_eq("post_rst_pending", 64'(bus.pending_any), 64'd0);
    check_eq("post_rst_ll_ready", 64'(bus.ll_ready), 64'd1);
    check_eq("post_rst_regwrite", 64'(bus.RegWrite), 64'd0);
    tick();

    // Issue rd=7, then its result arrives
    bus.rs1 = 5'd7;
    bus.ll_issue = 1'b1;
    bus.ll_issue_rd = 5'd7;
    sample();
    check_eq("t2_issue_stall", 64'(bus.issue_stall), 64'd0);
    check_eq("t2_stall_before_set", 64'(bus.stall_rs1), 64'd0);
    tick();
    idle_inputs();
    sample();
    check_eq("t2_stall_set", 64'(bus.stall_rs1), 64'd1);
    check_eq("t2_pending", 64'(bus.pending_any), 64'd1);
    tick();
    drive_ll(5'd7, 32'hDEADBEEF, 1'b1);
    sample();
    check_eq("t2_ll_ready", 64'(bus.ll_ready), 64'd1);
    check_eq("t2_stall_accept", 64'(bus.stall_rs1), 64'd1);
`ifdef WB_BYPASS_EN
    check_eq("t2_bypass_write", 64'(bus.RegWrite), 64'd1);
    tick();
    idle_inputs();
    sample();
    check_eq("t2_stall_clear", 64'(bus.stall_rs1), 64'd0);
    check_eq("t2_no_rewrite", 64'(bus.RegWrite), 64'd0);
`else
    check_eq("t2_no_write_yet", 64'(bus.RegWrite), 64'd0);
    tick();
    idle_inputs();
    sample();
    check_eq("t2_write", 64'(bus.RegWrite), 64'd1);
    check_eq("t2_write_rd", 64'(bus.rd), 64'd7);
    check_eq("t2_stall_write", 64'(bus.stall_rs1), 64'd1);
    tick();
    sample();
    check_eq("t2_stall_clear", 64'(bus.stall_rs1), 64'd0);
`endif
    check_eq("t2_pending_clear", 64'(bus.pending_any), 64'd0);
    tick();

    // Pipeline busy every cycle while two LL results arrive
    drive_pipe(5'd3, 32'h300);
    drive_ll(5'd8, 32'h80, 1'b1);
    sample();
    check_eq("t3_ready0", 64'(bus.ll_ready), 64'd1);
    tick();
    drive_pipe(5'd4, 32'h400);
    drive_ll(5'd9, 32'h90, 1'b1);
    sample();
    check_eq("t3_ready1", 64'(bus.ll_ready), 64'd1);
    tick();
    bus.ll_valid = 1'b0;
    drive_pipe(5'd5, 32'h500);
    sample();
    check_eq("t3_full_a", 64'(bus.ll_ready), 64'd0);
    tick();
    drive_pipe(5'd6, 32'h600);
    sample();
    check_eq("t3_full_b", 64'(bus.ll_ready), 64'd0);
    tick();
    idle_inputs();
    sample();
    check_eq("t3_drain8_rd", 64'(bus.rd), 64'd8);
    check_eq("t3_drain8_we", 64'(bus.RegWrite), 64'd1);
    tick();
    sample();
    check_eq("t3_drain9_rd", 64'(bus.rd), 64'd9);
    check_eq("t3_ready_after_pop", 64'(bus.ll_ready), 64'd1);
    tick();
    sample();
    check_eq("t3_drained", 64'(bus.RegWrite), 64'd0);
    tick();

    // pipe_we with rd=0 must not block the drain of the head
    drive_pipe(5'd10, 32'hA0);
    drive_ll(5'd12, 32'd5, 1'b1);
    sample();
    tick();
    bus.ll_valid = 1'b0;
    drive_pipe(5'd0, 32'h1234);
    sample();
    check_eq("t4_we", 64'(bus.RegWrite), 64'd1);
    check_eq("t4_rd", 64'(bus.rd), 64'd12);
    check_eq("t4_wd3", 64'(bus.WD3), 64'd5);
    tick();

    // Result for x0 is acknowledged and discarded
    idle_inputs();
    drive_ll(5'd0, 32'h55, 1'b1);
    sample();
    check_eq("t4_x0_ready", 64'(bus.ll_ready), 64'd1);
    check_eq("t4_x0_nowrite_a", 64'(bus.RegWrite), 64'd0);
    tick();
    idle_inputs();
    sample();
    check_eq("t4_x0_nowrite_b", 64'(bus.RegWrite), 64'd0);
    tick();

    // Issue of rd=4 in the same cycle its (untracked) result drains: set wins
    bus.rs1 = 5'd4;
    drive_pipe(5'd11, 32'hB0);
    drive_ll(5'd4, 32'h44, 1'b1);
    sample();
    tick();
    idle_inputs();
    bus.ll_issue = 1'b1;
    bus.ll_issue_rd = 5'd4;
    sample();
    check_eq("t5_drain_rd", 64'(bus.rd), 64'd4);
    check_eq("t5_issue_ok", 64'(bus.issue_stall), 64'd0);
    check_eq("t5_busy_before", 64'(bus.stall_rs1), 64'd0);
    tick();
    bus.ll_issue = 1'b0;
    sample();
    check_eq("t5_set_wins", 64'(bus.stall_rs1), 64'd1);
    tick();
    bus.ll_issue = 1'b1;
    sample();
    check_eq("t5_issue_stall", 64'(bus.issue_stall), 64'd1);
    tick();
    bus.ll_issue = 1'b0;
    sample();
    check_eq("t5_issue_stall_idle", 64'(bus.issue_stall), 64'd0);
    check_eq("t5_still_busy", 64'(bus.stall_rs1), 64'd1);
    tick();
    drive_ll(5'd4, 32'h444, 1'b1);
    sample();
    tick();
    idle_inputs();
    sample();
    tick();
    sample();
    check_eq("t5_cleared", 64'(bus.stall_rs1), 64'd0);
    check_eq("t5_pending_clear", 64'(bus.pending_any), 64'd0);
    tick();

    // Reset with two buffered entries and busy[8]/busy[9] set
    bus.rs1 = 5'd8;
    bus.rs2 = 5'd9;
    bus.ll_issue = 1'b1;
    bus.ll_issue_rd = 5'd8;
    sample();
    tick();
    bus.ll_issue_rd = 5'd9;
    sample();
    tick();
    bus.ll_issue = 1'b0;
    drive_pipe(5'd3, 32'h31);
    drive_ll(5'd8, 32'h88, 1'b1);
    sample();
    tick();
    drive_pipe(5'd3, 32'h32);
    drive_ll(5'd9, 32'h99, 1'b1);
    sample();
    tick();
    bus.ll_valid = 1'b0;
    drive_pipe(5'd3, 32'h33);
    sample();
    check_eq("t6_full", 64'(bus.ll_ready), 64'd0);
    check_eq("t6_stall8", 64'(bus.stall_rs1), 64'd1);
    check_eq("t6_stall9", 64'(bus.stall_rs2), 64'd1);
    tick();
    idle_inputs();
    rst_n = 1'b0;
    exp_q.delete();
    sample();
    check_eq("t6_rst_we", 64'(bus.RegWrite), 64'd0);
    check_eq("t6_rst_stall", 64'(bus.stall_rs1), 64'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sample();
      check_eq("t6_post_we", 64'(bus.RegWrite), 64'd0);
      check_eq("t6_post_stall8", 64'(bus.stall_rs1), 64'd0);
      check_eq("t6_post_stall9", 64'(bus.stall_rs2), 64'd0);
      check_eq("t6_post_pending", 64'(bus.pending_any), 64'd0);
      tick();
    end

    check_eq("outstanding_writes", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
